// File: rtl/simple_uart_rx_os.sv
// Oversampling UART receiver (8N1) with a show-ahead receive FIFO of 2^SIZE bytes.
// Define SIMPLE_UART_RX_MAJORITY_EN for 3-sample majority voting of every bit.
module simple_uart_rx_os #(
  parameter int unsigned SIZE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] clkdiv,
  output logic [7:0]  fifo_out,
  input  logic        fifo_read,
  output logic [5:0]  fifo_level,
  output logic        fifo_empty,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << SIZE;
  localparam logic [SIZE:0] FULL_LEVEL = {1'b1, {SIZE{1'b0}}};

`ifdef SIMPLE_UART_RX_MAJORITY_EN
  // The vote needs the sample after mid, so each decision lands one count later.
  localparam logic [16:0] LAT = 17'd1;
`else
  localparam logic [16:0] LAT = 17'd0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t            state;
  logic              rx_meta;
  logic              rxs;
  logic [15:0]       period;
  logic [16:0]       cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              bit_val;
  logic              sample_now;
  logic              push;
  logic              do_read;
  logic              do_write;
  logic              full;
  logic [7:0]        mem [DEPTH];
  logic [SIZE-1:0]   wptr;
  logic [SIZE-1:0]   rptr;
  logic [SIZE:0]     count;

`ifdef SIMPLE_UART_RX_MAJORITY_EN
  logic              rxs_d1;
  logic              rxs_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxs_d1 <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      rxs_d1 <= rxs;
      rxs_d2 <= rxs_d1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_comb begin
`ifdef SIMPLE_UART_RX_MAJORITY_EN
    bit_val = (rxs_d2 & rxs_d1) | (rxs_d2 & rxs) | (rxs_d1 & rxs);
`else
    bit_val = rxs;
`endif
    sample_now = 1'b0;
    case (state)
      START:      sample_now = (cnt == ({1'b0, period >> 1} + LAT));
      DATA, STOP: sample_now = (cnt == ({1'b0, period} + LAT));
      default:    sample_now = 1'b0;
    endcase
    push = (state == STOP) && sample_now && bit_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      period    <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      cnt       <= cnt + 17'd1;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state  <= START;
            period <= clkdiv;
            cnt    <= '0;
          end
        end
        START: begin
          if (sample_now) begin
            if (bit_val) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= LAT;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (sample_now) begin
            shreg <= {bit_val, shreg[7:1]};
            cnt   <= LAT;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (sample_now) begin
            if (bit_val) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
  assign full     = (count == FULL_LEVEL);
  assign do_read  = fifo_read && !fifo_empty;
  assign do_write = push && (!full || do_read);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !do_read;
      if (do_write) wptr <= wptr + 1'b1;
      if (do_read)  rptr <= rptr + 1'b1;
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wptr] <= shreg;
  end

  assign fifo_out   = mem[rptr];
  assign fifo_empty = (count == '0);
  assign fifo_level = 6'(count);

endmodule

// File: tb/tb_simple_uart_rx_os.sv
// Directed bench for simple_uart_rx_os: framing, false start, frame error, overrun,
// read-on-full-push, glitch rejection and mid-frame reset, with SIZE=2 and clkdiv=15.
module tb_simple_uart_rx_os;

  localparam int P = 16;
`ifdef SIMPLE_UART_RX_MAJORITY_EN
  localparam int          RD_J       = 11;
  localparam logic [7:0]  GLITCH_EXP = 8'h00;
`else
  localparam int          RD_J       = 10;
  localparam logic [7:0]  GLITCH_EXP = 8'h08;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] clkdiv;
  logic [7:0]  fifo_out;
  logic        fifo_read;
  logic [5:0]  fifo_level;
  logic        fifo_empty;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned fe_cnt   = 0;
  int unsigned ov_cnt   = 0;

  simple_uart_rx_os #(.SIZE(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .clkdiv     (clkdiv),
    .fifo_out   (fifo_out),
    .fifo_read  (fifo_read),
    .fifo_level (fifo_level),
    .fifo_empty (fifo_empty),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1)   ov_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit; each held for P clocks.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit, input int rd_j);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < P; j++) begin
        @(posedge clk);
        #1;
        rx = bits[b];
        if (glitch_bit >= 0 && b == glitch_bit + 1 && j == 8) rx = ~bits[b];
        fifo_read = (b == 9 && j == rd_j);
      end
    end
    fifo_read = 1'b0;
  endtask

  task automatic pop(output logic [7:0] d);
    d = fifo_out;
    fifo_read = 1'b1;
    @(posedge clk);
    #1;
    fifo_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; fifo_read = 1'b0; clkdiv = 16'd15;
    tick(3);
    n_checks++; if (fifo_level !== 6'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_single();
    int unsigned fe0, ov0;
    logic [7:0] d;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1, -1, -1);
    tick(4);
    n_checks++; if (fifo_out !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", fifo_out); end
    n_checks++; if (fifo_level !== 6'd1) begin n_fail++; $display("FAIL single_level: got %0d expected 1", fifo_level); end
    n_checks++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", fifo_empty); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    n_checks++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL single_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
    pop(d);
    n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL single_drained: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_false_start();
    int unsigned fe0;
    fe0 = fe_cnt;
    rx = 1'b0;
    tick(4);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL false_start_busy_mid: got %b expected 1", busy); end
    rx = 1'b1;
    tick(40);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_idle: got %b expected 0", busy); end
    n_checks++; if (fifo_level !== 6'd0) begin n_fail++; $display("FAIL false_start_level: got %0d expected 0", fifo_level); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL false_start_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_err();
    int unsigned fe0;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1, -1);
    tick(100);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b expected 1", busy); end
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL break_frame_err: got %0d pulses expected 1", fe_cnt - fe0); end
    n_checks++; if (fifo_level !== 6'd0) begin n_fail++; $display("FAIL break_level: got %0d expected 0", fifo_level); end
    rx = 1'b1;
    tick(5);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_release: got %b expected 0", busy); end
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL break_single_pulse: got %0d pulses expected 1", fe_cnt - fe0); end
  endtask

  task automatic test_overrun();
    int unsigned ov0;
    logic [7:0] d;
    logic [7:0] exp;
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1);
    tick(4);
    n_checks++; if (fifo_level !== 6'd4) begin n_fail++; $display("FAIL overrun_level: got %0d expected 4", fifo_level); end
    n_checks++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL overrun_pulse: got %0d pulses expected 1", ov_cnt - ov0); end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      pop(d);
      n_checks++; if (d !== exp) begin n_fail++; $display("FAIL overrun_read%0d: got %h expected %h", i, d, exp); end
    end
    n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL overrun_drained: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_read_on_push();
    int unsigned ov0;
    logic [7:0] d;
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h12; exp[2] = 8'h13; exp[3] = 8'h77;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, -1, -1);
    tick(2);
    n_checks++; if (fifo_level !== 6'd4) begin n_fail++; $display("FAIL rop_prefill: got %0d expected 4", fifo_level); end
    ov0 = ov_cnt;
    send_frame(8'h77, 1'b1, -1, RD_J);
    tick(4);
    n_checks++; if (fifo_level !== 6'd4) begin n_fail++; $display("FAIL rop_level: got %0d expected 4", fifo_level); end
    n_checks++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL rop_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
    for (int i = 0; i < 4; i++) begin
      pop(d);
      n_checks++; if (d !== exp[i]) begin n_fail++; $display("FAIL rop_read%0d: got %h expected %h", i, d, exp[i]); end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    send_frame(8'h00, 1'b1, 3, -1);
    tick(4);
    n_checks++; if (fifo_level !== 6'd1) begin n_fail++; $display("FAIL glitch_level: got %0d expected 1", fifo_level); end
    n_checks++; if (fifo_out !== GLITCH_EXP) begin n_fail++; $display("FAIL glitch_data: got %h expected %h", fifo_out, GLITCH_EXP); end
    pop(d);
  endtask

  task automatic test_reset_midframe();
    int unsigned fe0;
    fe0 = fe_cnt;
    rx = 1'b0;
    tick(40);
    rst = 1'b1;
    rx  = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(200);
    n_checks++; if (fifo_level !== 6'd0) begin n_fail++; $display("FAIL midreset_level: got %0d expected 0", fifo_level); end
    n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL midreset_empty: got %b expected 1", fifo_empty); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL midreset_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_read_on_push();
    test_glitch();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
